// File: rtl/osecpu_ctrl.sv
// OSECPU instruction sequencer: fetch/decode/execute FSM, program counter,
// and the Memory / IntegerRegister port drivers.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | mem_addr = pc; wait for run before moving on
// S_DECODE | latch instruction from memory, pc + 1, issue register reads
// S_EXEC   | register data valid; ALU/LIMM write, jumps, dispatch LD/ST
// S_MEM    | memory access at R[op1]; ST strobes mem_we here
// S_WB     | LD result returned on mem_rdata is written to R[op0]
// S_HALT   | sink; only reset leaves it
module osecpu_ctrl #(
  parameter int unsigned       PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     mem_wdata,
  output logic            mem_we,
  output logic [5:0]      ireg_r0,
  output logic [5:0]      ireg_r1,
  input  logic [31:0]     ireg_d0,
  input  logic [31:0]     ireg_d1,
  output logic [5:0]      ireg_rw,
  output logic [31:0]     ireg_dw,
  output logic            ireg_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LIMM = 8'h02;
  localparam logic [7:0] OP_LD   = 8'h08;
  localparam logic [7:0] OP_ST   = 8'h09;
  localparam logic [7:0] OP_OR   = 8'h10;
  localparam logic [7:0] OP_XOR  = 8'h11;
  localparam logic [7:0] OP_AND  = 8'h12;
  localparam logic [7:0] OP_ADD  = 8'h14;
  localparam logic [7:0] OP_SUB  = 8'h15;
  localparam logic [7:0] OP_JMP  = 8'h20;
  localparam logic [7:0] OP_BNZ  = 8'h21;
  localparam logic [7:0] OP_HALT = 8'hFF;

  state_t          state, state_nxt;
  logic [31:0]     instr;
  logic [PC_W-1:0] addr_q;   // R[op1] captured in EXEC, used as MEM address
  logic [31:0]     data_q;   // R[op2] captured in EXEC, used as store data

  logic [7:0]  op;
  logic [5:0]  op0;
  logic [15:0] imm16;

  assign op        = instr[31:24];
  assign op0       = instr[23:18];
  assign imm16     = instr[15:0];
  assign mem_wdata = data_q;

  // State, pc, instruction and operand registers; reset aborts anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      instr   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_DECODE: begin
          instr <= mem_rdata;
          pc    <= pc + PC_W'(1);
        end
        S_EXEC: begin
          addr_q <= ireg_d0[PC_W-1:0];
          data_q <= ireg_d1;
          if (op == OP_JMP || (op == OP_BNZ && ireg_d0 != 32'd0))
            pc <= PC_W'(imm16);
          if (state_nxt == S_HALT) begin
            halted  <= 1'b1;
            illegal <= (op != OP_HALT);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and port drive; strobes are forced low while reset is asserted.
  always_comb begin
    state_nxt = state;
    mem_addr  = pc;
    mem_we    = 1'b0;
    ireg_r0   = instr[17:12];
    ireg_r1   = instr[11:6];
    ireg_rw   = op0;
    ireg_dw   = '0;
    ireg_we   = 1'b0;
    case (state)
      S_FETCH: begin
        if (run) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Instruction is not latched yet, so read ports come straight from memory.
        ireg_r0   = (mem_rdata[31:24] == OP_BNZ) ? mem_rdata[23:18] : mem_rdata[17:12];
        ireg_r1   = mem_rdata[11:6];
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (op)
          OP_NOP, OP_JMP, OP_BNZ: ;
          OP_LIMM: begin
            ireg_dw = {{16{imm16[15]}}, imm16};
            ireg_we = 1'b1;
          end
          OP_OR:  begin ireg_dw = ireg_d0 | ireg_d1; ireg_we = 1'b1; end
          OP_XOR: begin ireg_dw = ireg_d0 ^ ireg_d1; ireg_we = 1'b1; end
          OP_AND: begin ireg_dw = ireg_d0 & ireg_d1; ireg_we = 1'b1; end
          OP_ADD: begin ireg_dw = ireg_d0 + ireg_d1; ireg_we = 1'b1; end
          OP_SUB: begin ireg_dw = ireg_d0 - ireg_d1; ireg_we = 1'b1; end
          OP_LD, OP_ST: state_nxt = S_MEM;
          default: state_nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_addr = addr_q;
        if (op == OP_ST) begin
          mem_we    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        ireg_dw   = mem_rdata;
        ireg_we   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: ;
      default: state_nxt = S_FETCH;
    endcase
    if (!reset) begin
      mem_we  = 1'b0;
      ireg_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_osecpu_ctrl.sv
// Directed bench for osecpu_ctrl with behavioural memory and register file.
module tb_osecpu_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [5:0]  ireg_r0, ireg_r1, ireg_rw;
  logic [31:0] ireg_d0, ireg_d1, ireg_dw;
  logic        ireg_we;
  logic [15:0] pc;
  logic        halted, illegal;

  logic [31:0] mem  [0:65535];
  logic [31:0] regs [0:63];

  int tests = 0;
  int fails = 0;
  int cyc;
  int we_cnt = 0;
  int we_cyc [0:255];
  int mw_cnt = 0;
  logic [15:0] mw_addr = '0;

  osecpu_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ireg_r0(ireg_r0), .ireg_r1(ireg_r1), .ireg_d0(ireg_d0), .ireg_d1(ireg_d1),
    .ireg_rw(ireg_rw), .ireg_dw(ireg_dw), .ireg_we(ireg_we),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory and register file, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (ireg_we) regs[ireg_rw] <= ireg_dw;
    ireg_d0 <= regs[ireg_r0];
    ireg_d1 <= regs[ireg_r1];
    cyc <= (!reset) ? 1 : cyc + 1;
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ireg_we && we_cnt < 256) begin
      we_cyc[we_cnt] = cyc;
      we_cnt = we_cnt + 1;
    end
    if (mem_we) begin
      mw_cnt  = mw_cnt + 1;
      mw_addr = mem_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] enc_r(input logic [7:0] o, input logic [5:0] a,
                                        input logic [5:0] b, input logic [5:0] c);
    return {o, a, b, c, 6'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [7:0] o, input logic [5:0] a,
                                        input logic [15:0] imm);
    return {o, a, 2'b00, imm};
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) regs[i] = '0;
    regs[6] = 32'hDEADBEEF;

    mem[0]        = enc_i(8'h02, 6'd1, 16'h8001);
    mem[1]        = enc_i(8'h02, 6'd2, 16'h0005);
    mem[2]        = enc_i(8'h02, 6'd1, 16'hFFFF);
    mem[3]        = enc_i(8'h02, 6'd2, 16'h0001);
    mem[4]        = enc_r(8'h14, 6'd3, 6'd1, 6'd2);
    mem[5]        = enc_r(8'h15, 6'd4, 6'd2, 6'd1);
    mem[6]        = enc_i(8'h02, 6'd5, 16'h0040);
    mem[7]        = enc_r(8'h09, 6'd0, 6'd5, 6'd6);
    mem[8]        = enc_r(8'h08, 6'd7, 6'd5, 6'd0);
    mem[9]        = 32'h0000_0000;
    mem[10]       = enc_i(8'h21, 6'd0, 16'h0100);
    mem[11]       = enc_i(8'h02, 6'd0, 16'h0003);
    mem[12]       = enc_i(8'h21, 6'd0, 16'h0100);
    mem[16'h0100] = enc_i(8'h20, 6'd0, 16'hFFFF);
    mem[16'hFFFF] = enc_i(8'h20, 6'd0, 16'h0014);
    mem[20]       = 32'h7E00_0000;

    run = 1'b1;
    do_reset();
    chk("rst_pc",      {16'd0, pc}, 32'd0);
    chk("rst_halted",  {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_strobes", {30'd0, mem_we, ireg_we}, 32'd0);

    tick(3); tick(3);
    chk("limm_r1",   regs[1], 32'hFFFF8001);
    chk("limm_r2",   regs[2], 32'h00000005);
    chk("we_cyc0",   we_cyc[0], 32'd3);
    chk("we_cyc1",   we_cyc[1], 32'd6);
    chk("pc_after2", {16'd0, pc}, 32'd2);

    tick(3); tick(3); tick(3);
    chk("add_r3",    regs[3], 32'h00000000);
    chk("add_pc",    {16'd0, pc}, 32'd5);
    tick(3);
    chk("sub_r4",    regs[4], 32'h00000002);

    tick(3); tick(4);
    chk("st_pc",     {16'd0, pc}, 32'd8);
    chk("st_cnt",    mw_cnt, 32'd1);
    chk("st_addr",   {16'd0, mw_addr}, 32'h40);
    chk("st_data",   mem[16'h0040], 32'hDEADBEEF);
    tick(4);
    chk("ld_not_done", {16'd0, mem_addr}, 32'd9);
    chk("ld_r7_pend",  regs[7], 32'h00000000);
    tick(1);
    chk("ld_r7",     regs[7], 32'hDEADBEEF);
    chk("ld_wb_cyc", we_cyc[we_cnt-1], 32'd30);
    chk("ld_pc",     {16'd0, pc}, 32'd9);
    chk("ld_no_mw",  mw_cnt, 32'd1);

    tick(3); tick(3);
    chk("bnz_zero",  {16'd0, pc}, 32'd11);
    tick(3); tick(3);
    chk("bnz_taken", {16'd0, pc}, 32'h0100);
    tick(3);
    chk("jmp_ffff",  {16'd0, pc}, 32'hFFFF);
    tick(2);
    chk("pc_wrap",   {16'd0, pc}, 32'd0);
    tick(1);
    chk("jmp_wrap",  {16'd0, pc}, 32'd20);

    tick(3);
    chk("ill_halted",  {31'd0, halted}, 32'd1);
    chk("ill_illegal", {31'd0, illegal}, 32'd1);
    begin
      int we_before;
      we_before = we_cnt;
      tick(5);
      chk("halt_pc",   {16'd0, pc}, 32'd21);
      chk("halt_we",   we_cnt, we_before);
      chk("halt_mw",   mw_cnt, 32'd1);
    end

    mem[0] = 32'hFF00_0000;
    do_reset();
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    tick(3);
    chk("hlt_halted",  {31'd0, halted}, 32'd1);
    chk("hlt_illegal", {31'd0, illegal}, 32'd0);
    chk("hlt_pc",      {16'd0, pc}, 32'd1);

    mem[0]  = enc_r(8'h09, 6'd0, 6'd5, 6'd6);
    regs[6] = 32'h12345678;
    run = 1'b0;
    do_reset();
    tick(5);
    chk("run0_pc",   {16'd0, pc}, 32'd0);
    chk("run0_addr", {16'd0, mem_addr}, 32'd0);
    run = 1'b1;
    tick(3);
    chk("mem_st_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    tick(1);
    chk("rst_mem_pc",   {16'd0, pc}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_keep", mem[16'h0040], 32'hDEADBEEF);
    chk("rst_mem_cnt",  mw_cnt, 32'd1);
    reset = 1'b1;
    tick(4);
    chk("st_after_rst", mem[16'h0040], 32'h12345678);
    chk("st_cnt2",      mw_cnt, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
